// File: rtl/reg_file_arb_pkg.sv
// Shared types and helpers for the register-file access arbiter.
package reg_file_arb_pkg;

    // Widest address and data the latched request can carry. Instances narrower than
    // this zero-extend into the request and slice back out.
    localparam int unsigned MAX_ADDR_WIDTH = 16;
    localparam int unsigned MAX_DATA_WIDTH = 256;
    localparam int unsigned MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic                      write;
        logic [MAX_ADDR_WIDTH-1:0] addr;
        logic [MAX_DATA_WIDTH-1:0] wdata;
        logic [MAX_STRB_WIDTH-1:0] wstrb;
    } req_t;

    // True when the register index maps to an implemented register.
    function automatic logic addr_in_range(input logic [MAX_ADDR_WIDTH-1:0] addr,
                                           input int unsigned num_registers);
        return (32'(addr) < num_registers);
    endfunction

endpackage

// File: rtl/reg_file_access_arbiter_rr_arbiter.sv
// Round-robin winner search with a registered priority pointer.
module rr_arbiter #(
    parameter int unsigned NUM_REQUESTERS = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [NUM_REQUESTERS-1:0]         i_req,
    input  logic                              i_advance,
    output logic [NUM_REQUESTERS-1:0]         o_grant,
    output logic [$clog2(NUM_REQUESTERS)-1:0] o_idx,
    output logic                              o_any
);

    localparam int unsigned IDX_WIDTH = $clog2(NUM_REQUESTERS);

    logic [IDX_WIDTH-1:0] r_ptr;

    // Winner is the first set request at or after the pointer, searching upward with wrap.
    always_comb begin
        int unsigned cand;
        o_any   = 1'b0;
        o_idx   = '0;
        o_grant = '0;
        cand    = 0;
        for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
            cand = (32'(r_ptr) + k) % NUM_REQUESTERS;
            if (!o_any && i_req[cand]) begin
                o_any = 1'b1;
                o_idx = IDX_WIDTH'(cand);
            end
        end
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

    // Pointer moves just past the winner on each accepted grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_idx == IDX_WIDTH'(NUM_REQUESTERS - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_access_arbiter.sv
// Shares the register file direct-access port between several requesters.
// Each grant runs IDLE (accept) -> ACCESS (strobe) -> RESP (response) -> IDLE.
module reg_file_access_arbiter
    import reg_file_arb_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 4,
    parameter int unsigned REGISTER_WIDTH = 32,
    parameter int unsigned NUM_REGISTERS  = 16,
    parameter int unsigned ADDR_WIDTH     = 4
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic [NUM_REQUESTERS-1:0]                i_req_valid,
    output logic [NUM_REQUESTERS-1:0]                o_req_ready,
    input  logic [NUM_REQUESTERS-1:0]                i_req_write,
    input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0]     i_req_addr,
    input  logic [NUM_REQUESTERS*REGISTER_WIDTH-1:0] i_req_wdata,
    input  logic [NUM_REQUESTERS*REGISTER_WIDTH/8-1:0] i_req_wstrb,
    output logic [NUM_REQUESTERS-1:0]                o_rsp_valid,
    output logic [REGISTER_WIDTH-1:0]                o_rsp_rdata,
    output logic                                     o_rsp_err,
    output logic                                     o_reg_en,
    output logic                                     o_reg_we,
    output logic [ADDR_WIDTH-1:0]                    o_reg_addr,
    output logic [REGISTER_WIDTH-1:0]                o_reg_wdata,
    output logic [REGISTER_WIDTH/8-1:0]              o_reg_wstrb,
    input  logic [REGISTER_WIDTH-1:0]                i_reg_rdata,
    output logic [NUM_REGISTERS-1:0]                 o_reg_trigger
);

    localparam int unsigned STRB_WIDTH = REGISTER_WIDTH / 8;
    localparam int unsigned IDX_WIDTH  = $clog2(NUM_REQUESTERS);

    state_e                r_state;
    state_e                w_state_next;
    logic [IDX_WIDTH-1:0]  r_winner;
    req_t                  r_req;
    req_t                  w_sel_req;
    logic [NUM_REQUESTERS-1:0] w_grant;
    logic [IDX_WIDTH-1:0]  w_idx;
    logic                  w_any;
    logic                  w_accept;
    logic                  w_in_range;

    rr_arbiter #(
        .NUM_REQUESTERS (NUM_REQUESTERS)
    ) u_rr_arbiter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant),
        .o_idx     (w_idx),
        .o_any     (w_any)
    );

    // A grant is only taken in IDLE and never while reset is asserted.
    assign w_accept   = (r_state == IDLE) && w_any && !i_rst;
    assign w_in_range = addr_in_range(r_req.addr, NUM_REGISTERS);

    // Pick the winning requester's fields out of the packed request buses.
    always_comb begin
        w_sel_req       = '0;
        w_sel_req.write = i_req_write[w_idx];
        w_sel_req.addr  = MAX_ADDR_WIDTH'(i_req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH]);
        w_sel_req.wdata = MAX_DATA_WIDTH'(i_req_wdata[w_idx*REGISTER_WIDTH +: REGISTER_WIDTH]);
        w_sel_req.wstrb = MAX_STRB_WIDTH'(i_req_wstrb[w_idx*STRB_WIDTH +: STRB_WIDTH]);
    end

    // State register and request latch; reset drops any in-flight access.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_winner <= '0;
            r_req    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_winner <= w_idx;
                r_req    <= w_sel_req;
            end
        end
    end

    // Fixed three-state sequence per access.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_next = ACCESS;
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Per-state outputs; everything defaults to zero outside its owning state.
    always_comb begin
        o_req_ready   = '0;
        o_rsp_valid   = '0;
        o_rsp_rdata   = '0;
        o_rsp_err     = 1'b0;
        o_reg_en      = 1'b0;
        o_reg_we      = 1'b0;
        o_reg_addr    = '0;
        o_reg_wdata   = '0;
        o_reg_wstrb   = '0;
        o_reg_trigger = '0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    o_req_ready = w_grant;
                end
            end
            ACCESS: begin
                if (w_in_range) begin
                    o_reg_en    = 1'b1;
                    o_reg_we    = r_req.write;
                    o_reg_addr  = r_req.addr[ADDR_WIDTH-1:0];
                    o_reg_wdata = r_req.wdata[REGISTER_WIDTH-1:0];
                    o_reg_wstrb = r_req.wstrb[STRB_WIDTH-1:0];
                end
            end
            RESP: begin
                o_rsp_valid[r_winner] = 1'b1;
                o_rsp_err             = !w_in_range;
                if (w_in_range && !r_req.write) begin
                    o_rsp_rdata = i_reg_rdata;
                end
                // Trigger fires for any in-range write, including an all-zero strobe.
                if (w_in_range && r_req.write) begin
                    for (int unsigned i = 0; i < NUM_REGISTERS; i++) begin
                        if (32'(r_req.addr) == i) begin
                            o_reg_trigger[i] = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_file_access_arbiter.sv
// Self-checking bench for reg_file_access_arbiter: directed scenarios plus a randomized run
// checked against a behavioural model (round-robin rule, memory array, fixed 3-cycle timing).
module tb_reg_file_access_arbiter;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int NREG = 12;
    localparam int AW   = 4;
    localparam int SW   = W / 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*W-1:0]  req_wdata = '0;
    logic [N*SW-1:0] req_wstrb = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [W-1:0]    rsp_rdata;
    logic            rsp_err;
    logic            reg_en;
    logic            reg_we;
    logic [AW-1:0]   reg_addr;
    logic [W-1:0]    reg_wdata;
    logic [SW-1:0]   reg_wstrb;
    logic [W-1:0]    rf_rdata;
    logic [NREG-1:0] reg_trigger;

    logic [W-1:0]    rf_mem  [16];
    logic [W-1:0]    ref_mem [NREG];
    int              total = 0;
    int              bad   = 0;
    int              model_ptr = 0;

    reg_file_access_arbiter #(
        .NUM_REQUESTERS (N),
        .REGISTER_WIDTH (W),
        .NUM_REGISTERS  (NREG),
        .ADDR_WIDTH     (AW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_write   (req_write),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .i_req_wstrb   (req_wstrb),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_reg_en      (reg_en),
        .o_reg_we      (reg_we),
        .o_reg_addr    (reg_addr),
        .o_reg_wdata   (reg_wdata),
        .o_reg_wstrb   (reg_wstrb),
        .i_reg_rdata   (rf_rdata),
        .o_reg_trigger (reg_trigger)
    );

    always #5 clk = ~clk;

    // Register file storage behind the port: byte-strobed write, registered read.
    always @(posedge clk) begin
        if (reg_en) begin
            if (reg_we) begin
                for (int b = 0; b < SW; b++) begin
                    if (reg_wstrb[b]) rf_mem[reg_addr][b*8 +: 8] <= reg_wdata[b*8 +: 8];
                end
            end
            rf_rdata <= rf_mem[reg_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic wr, input logic [AW-1:0] a,
                           input logic [W-1:0] d, input logic [SW-1:0] s);
        req_write[r]         = wr;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*W +: W]  = d;
        req_wstrb[r*SW +: SW] = s;
    endtask

    task automatic ref_write(input int a, input logic [W-1:0] d, input logic [SW-1:0] s);
        for (int b = 0; b < SW; b++) begin
            if (s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        total++; if (req_ready !== '0) begin bad++; $display("FAIL rst_ready got=%0h exp=0", req_ready); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL rst_rsp_valid got=%0h exp=0", rsp_valid); end
        total++; if ({rsp_err, reg_en, reg_we} !== 3'b000) begin
            bad++; $display("FAIL rst_strobes got=%b exp=000", {rsp_err, reg_en, reg_we});
        end
        total++; if ({rsp_rdata, reg_addr, reg_wdata, reg_wstrb} !== '0) begin
            bad++; $display("FAIL rst_buses got=%0h exp=0", {rsp_rdata, reg_addr, reg_wdata, reg_wstrb});
        end
        total++; if (reg_trigger !== '0) begin bad++; $display("FAIL rst_trigger got=%0h exp=0", reg_trigger); end
        step();
        rst = 1'b0;
        model_ptr = 0;
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
        req_valid = 4'b0001;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wr_ready got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        @(negedge clk);
        total++; if ({reg_en, reg_we} !== 2'b11) begin bad++; $display("FAIL wr_en_we got=%b exp=11", {reg_en, reg_we}); end
        total++; if (reg_addr !== 4'd3) begin bad++; $display("FAIL wr_addr got=%0d exp=3", reg_addr); end
        total++; if (reg_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_wdata got=%0h exp=deadbeef", reg_wdata); end
        total++; if (reg_wstrb !== 4'hF) begin bad++; $display("FAIL wr_wstrb got=%0h exp=f", reg_wstrb); end
        step();
        @(negedge clk);
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL wr_rsp_valid got=%b exp=0001", rsp_valid); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL wr_rsp_err got=%b exp=0", rsp_err); end
        total++; if (reg_trigger !== 12'h008) begin bad++; $display("FAIL wr_trigger got=%0h exp=8", reg_trigger); end
        ref_write(3, 32'hDEADBEEF, 4'hF);
        model_ptr = 1;
        step();
    endtask

    task automatic test_read_back();
        set_req(0, 1'b0, 4'd3, 32'h0, 4'h0);
        req_valid = 4'b0001;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rd_ready got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        @(negedge clk);
        total++; if ({reg_en, reg_we} !== 2'b10) begin bad++; $display("FAIL rd_en_we got=%b exp=10", {reg_en, reg_we}); end
        step();
        @(negedge clk);
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL rd_rsp_valid got=%b exp=0001", rsp_valid); end
        total++; if (rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata got=%0h exp=deadbeef", rsp_rdata); end
        total++; if (reg_trigger !== '0) begin bad++; $display("FAIL rd_trigger got=%0h exp=0", reg_trigger); end
        model_ptr = 1;
        step();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] exp_ready;
        for (int r = 0; r < N; r++) set_req(r, 1'b0, 4'd0, 32'h0, 4'h0);
        req_valid = 4'hF;
        rst = 1'b1;
        step();
        @(negedge clk);
        total++; if (req_ready !== '0) begin bad++; $display("FAIL rr_ready_in_reset got=%b exp=0000", req_ready); end
        step();
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            exp_ready = '0;
            if (c % 3 == 0) exp_ready[order[c/3]] = 1'b1;
            total++; if ($countones(req_ready) > 1) begin bad++; $display("FAIL rr_multi_hot got=%b exp=onehot", req_ready); end
            total++; if (req_ready !== exp_ready) begin
                bad++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", c, req_ready, exp_ready);
            end
            step();
        end
        req_valid = '0;
        model_ptr = 1;
    endtask

    task automatic test_out_of_range();
        set_req(2, 1'b1, 4'd13, 32'hCAFEF00D, 4'hF);
        req_valid = 4'b0100;
        @(negedge clk);
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL oor_ready got=%b exp=0100", req_ready); end
        step();
        req_valid = '0;
        @(negedge clk);
        total++; if (reg_en !== 1'b0) begin bad++; $display("FAIL oor_reg_en got=%b exp=0", reg_en); end
        step();
        @(negedge clk);
        total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL oor_rsp_valid got=%b exp=0100", rsp_valid); end
        total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL oor_rsp_err got=%b exp=1", rsp_err); end
        total++; if (rsp_rdata !== '0) begin bad++; $display("FAIL oor_rdata got=%0h exp=0", rsp_rdata); end
        total++; if (reg_trigger !== '0) begin bad++; $display("FAIL oor_trigger got=%0h exp=0", reg_trigger); end
        model_ptr = 3;
        step();
    endtask

    task automatic test_zero_strobe();
        set_req(1, 1'b1, 4'd5, 32'h55AA55AA, 4'h0);
        req_valid = 4'b0010;
        @(negedge clk);
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL zs_ready got=%b exp=0010", req_ready); end
        step();
        req_valid = '0;
        @(negedge clk);
        total++; if ({reg_en, reg_we} !== 2'b11) begin bad++; $display("FAIL zs_en_we got=%b exp=11", {reg_en, reg_we}); end
        total++; if (reg_wstrb !== 4'h0) begin bad++; $display("FAIL zs_wstrb got=%0h exp=0", reg_wstrb); end
        step();
        @(negedge clk);
        total++; if (reg_trigger !== 12'h020) begin bad++; $display("FAIL zs_trigger got=%0h exp=20", reg_trigger); end
        total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL zs_rsp_valid got=%b exp=0010", rsp_valid); end
        model_ptr = 2;
        step();
    endtask

    task automatic test_reset_mid();
        set_req(1, 1'b1, 4'd7, 32'h12345678, 4'b0011);
        req_valid = 4'b0010;
        @(negedge clk);
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rm_ready got=%b exp=0010", req_ready); end
        step();
        req_valid = '0;
        rst = 1'b1;
        // The strobe in this ACCESS cycle reaches storage before reset lands.
        ref_write(7, 32'h12345678, 4'b0011);
        step();
        rst = 1'b0;
        @(negedge clk);
        total++; if ({req_ready, rsp_valid, rsp_err, reg_en, reg_we} !== '0) begin
            bad++; $display("FAIL rm_ctrl_after got=%0h exp=0", {req_ready, rsp_valid, rsp_err, reg_en, reg_we});
        end
        total++; if ({rsp_rdata, reg_addr, reg_wdata, reg_wstrb, reg_trigger} !== '0) begin
            bad++; $display("FAIL rm_buses_after got=%0h exp=0", {rsp_rdata, reg_addr, reg_wdata, reg_wstrb, reg_trigger});
        end
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            total++; if (rsp_valid !== '0) begin bad++; $display("FAIL rm_no_rsp got=%b exp=0000", rsp_valid); end
        end
        step();
        for (int r = 0; r < N; r++) set_req(r, 1'b0, 4'd7, 32'h0, 4'h0);
        req_valid = 4'hF;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rm_ptr_zero got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        step();
        @(negedge clk);
        total++; if (rsp_rdata !== 32'h00005678) begin bad++; $display("FAIL rm_kept_write got=%0h exp=5678", rsp_rdata); end
        model_ptr = 1;
        step();
    endtask

    task automatic test_random();
        logic [N-1:0]    mask;
        logic [N-1:0]    exp_ready;
        logic [NREG-1:0] exp_trig;
        logic [W-1:0]    exp_rdata;
        logic            wr;
        logic [AW-1:0]   a;
        logic [W-1:0]    d;
        logic [SW-1:0]   s;
        logic            in_range;
        int              win;
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = '0;
                @(negedge clk);
                total++; if (req_ready !== '0) begin bad++; $display("FAIL rnd_idle_ready got=%b exp=0000", req_ready); end
                step();
            end
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int r = 0; r < N; r++) begin
                set_req(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                        SW'($urandom_range(0, 15)));
            end
            req_valid = mask;
            win = -1;
            for (int k = 0; k < N; k++) begin
                if (win < 0 && mask[(model_ptr + k) % N]) win = (model_ptr + k) % N;
            end
            model_ptr = (win + 1) % N;
            wr = req_write[win];
            a  = req_addr[win*AW +: AW];
            d  = req_wdata[win*W +: W];
            s  = req_wstrb[win*SW +: SW];
            in_range = (int'(a) < NREG);
            exp_ready = '0;
            exp_ready[win] = 1'b1;
            @(negedge clk);
            total++; if (req_ready !== exp_ready) begin
                bad++; $display("FAIL rnd_ready t=%0d got=%b exp=%b", t, req_ready, exp_ready);
            end
            step();
            req_valid = '0;
            @(negedge clk);
            total++; if (reg_en !== in_range) begin bad++; $display("FAIL rnd_reg_en t=%0d got=%b exp=%b", t, reg_en, in_range); end
            if (in_range) begin
                total++; if ({reg_we, reg_addr, reg_wdata, reg_wstrb} !== {wr, a, d, s}) begin
                    bad++; $display("FAIL rnd_access t=%0d got=%0h exp=%0h", t,
                                    {reg_we, reg_addr, reg_wdata, reg_wstrb}, {wr, a, d, s});
                end
            end
            step();
            exp_trig  = '0;
            exp_rdata = '0;
            if (in_range && wr) exp_trig[a] = 1'b1;
            if (in_range && !wr) exp_rdata = ref_mem[a];
            @(negedge clk);
            total++; if (rsp_valid !== exp_ready) begin bad++; $display("FAIL rnd_rsp_valid t=%0d got=%b exp=%b", t, rsp_valid, exp_ready); end
            total++; if (rsp_err !== !in_range) begin bad++; $display("FAIL rnd_rsp_err t=%0d got=%b exp=%b", t, rsp_err, !in_range); end
            total++; if (rsp_rdata !== exp_rdata) begin bad++; $display("FAIL rnd_rdata t=%0d got=%0h exp=%0h", t, rsp_rdata, exp_rdata); end
            total++; if (reg_trigger !== exp_trig) begin bad++; $display("FAIL rnd_trigger t=%0d got=%0h exp=%0h", t, reg_trigger, exp_trig); end
            if (in_range && wr) ref_write(int'(a), d, s);
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = '0;
        for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
        rf_rdata = '0;
        test_reset();
        test_single_write();
        test_read_back();
        test_round_robin();
        test_out_of_range();
        test_zero_strobe();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_access_arbiter.md
Name: reg_file_access_arbiter

Overview:
Shares the single hardware direct-access port of the AXI-lite register file between NUM_REQUESTERS independent requesters, for example the AXI-lite slave decode, a DMA descriptor engine and debug logic.
It uses round-robin arbitration and runs each granted access through a fixed 3-state sequence: accept, access, respond.
Each requester gets its own response, and a per-register trigger pulses when a write completes.
The block sits between the requesters and the register file storage.

Parameters:
NUM_REQUESTERS, 4, number of requester ports (2..8)
REGISTER_WIDTH, 32, data width in bits (multiple of 8)
NUM_REGISTERS, 16, number of implemented registers
ADDR_WIDTH, 4, register index width; must be >= $clog2(NUM_REGISTERS)

Ports:
clk  in  1  single clock; all logic is rising-edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQUESTERS  request pending, one bit per requester
req_ready  out  NUM_REQUESTERS  request accepted this cycle
req_write  in  NUM_REQUESTERS  1 = write, 0 = read
req_addr  in  NUM_REQUESTERS*ADDR_WIDTH  register index, packed per requester
req_wdata  in  NUM_REQUESTERS*REGISTER_WIDTH  write data
req_wstrb  in  NUM_REQUESTERS*REGISTER_WIDTH/8  byte strobes
rsp_valid  out  NUM_REQUESTERS  one-cycle response pulse
rsp_rdata  out  REGISTER_WIDTH  read data, shared by all requesters, valid only with rsp_valid
rsp_err  out  1  address out of range, valid only with rsp_valid
reg_en  out  1  register file access strobe
reg_we  out  1  write enable, qualified by reg_en
reg_addr  out  ADDR_WIDTH  register index
reg_wdata  out  REGISTER_WIDTH  write data
reg_wstrb  out  REGISTER_WIDTH/8  byte strobes
reg_rdata  in  REGISTER_WIDTH  read data, valid one cycle after reg_en
reg_trigger  out  NUM_REGISTERS  one-cycle pulse per successfully written register

Behaviour:
- Reset values: all outputs are 0, the FSM is in IDLE and the round-robin pointer is 0.
- Reset mid-operation: the in-flight access is dropped, with no response and no trigger. A register write already strobed stays in the register file.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE, with no other transitions.
- IDLE:
  - If any req_valid is set, the winner is the first set bit at or after the pointer, searching upward with wrap.
  - req_ready[winner] is asserted combinationally in this cycle. At most one req_ready bit is ever set.
  - The winner index and its write/addr/wdata/wstrb are latched.
  - Pointer becomes (winner+1) mod NUM_REQUESTERS.
  - Next state is ACCESS.
- ACCESS:
  - If the latched address is < NUM_REGISTERS: reg_en=1, reg_we=latched write, and reg_addr/wdata/wstrb are driven from the latch.
  - If the address is out of range: reg_en stays 0.
  - Next state is RESP.
- RESP:
  - rsp_valid[winner]=1 for exactly one cycle.
  - rsp_rdata = reg_rdata for an in-range read; 0 for writes and for errors.
  - rsp_err=1 exactly when the address is out of range.
  - For an in-range write, reg_trigger[addr]=1 in this same cycle. This holds even when wstrb=0.
  - Next state is IDLE.
- Timing: accept at cycle T, reg_en at T+1, rsp_valid at T+2. The next accept is at T+3 at the earliest, so peak throughput is one access per 3 cycles.
- Requesters must hold req_* stable while req_valid=1 and req_ready=0.
- Deasserting req_valid before it is accepted is legal; that request is simply not served.
- reg_en, reg_we, rsp_valid and reg_trigger are 0 in every state not listed above.
- With a single active requester, it is served every 3 cycles. The pointer still advances.

Decomposition:
- Package reg_file_arb_pkg holds:
  - state enum type: IDLE, ACCESS, RESP
  - request struct: write, addr, wdata, wstrb, sized by parameters
  - function for the in-range address check
- Sub-module rr_arbiter, parameterised by NUM_REQUESTERS. It contains:
  - a combinational winner search from the pointer
  - the registered pointer, updated on an enable input
  - a one-hot grant output and an index output

Test Plan:
1. After reset, single write: req0 writes addr 3, wdata 0xDEADBEEF, wstrb 0xF.
   -> req_ready[0] at T; reg_en=1, reg_we=1, reg_addr=3 at T+1; rsp_valid[0], rsp_err=0, reg_trigger=0x0008 at T+2.
2. Read back: the register file model returns 0xDEADBEEF.
   -> rsp_rdata=0xDEADBEEF with rsp_valid[0] two cycles after accept; reg_trigger=0.
3. All four requesters hold req_valid continuously from reset.
   -> grant order is 0,1,2,3,0, spaced 3 cycles apart; req_ready is never multi-hot.
4. Out-of-range access: NUM_REGISTERS=12, req2 writes addr 13.
   -> reg_en stays 0; rsp_valid[2]=1 with rsp_err=1 and rsp_rdata=0; no trigger.
5. Reset asserted in the ACCESS cycle.
   -> next cycle all outputs are 0 and no rsp_valid is produced; the subsequent grant goes to req0 (pointer is 0).
6. Zero-strobe write: wstrb=0 to addr 5.
   -> reg_en=1, reg_we=1, reg_wstrb=0; reg_trigger[5] pulses in the RESP cycle.
